// File: rtl/mul_18.sv
// Sequential sign-magnitude fixed-point multiplier.
// One magnitude bit per clock, start/complete/overflow handshake.
module mul_18 #(
  parameter int Q = 17,
  parameter int N = 18
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_start,
  output logic [N-1:0] o_product_out,
  output logic         o_complete,
  output logic         o_overflow,
  output logic         o_busy
);

  localparam int W2 = 2*N-2;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W2-1:0] mcand_q, mcand_d;
  logic [N-2:0]  mplier_q, mplier_d;
  logic [W2-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dcnt_q, dcnt_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  product_q, product_d;
  logic          ovf_q, ovf_d;

  logic [W2-1:0] sum_w;
  logic [W2-1:0] shf_w;
  logic          ovf_w;
  logic [N-2:0]  mag_w;

  // Accumulate step and result formatting from the final sum
  always_comb begin
    sum_w = acc_q;
    if (mplier_q[0]) sum_w = acc_q + mcand_q;
    shf_w = sum_w >> Q;
    ovf_w = |(shf_w >> (N-1));
    mag_w = ovf_w ? '1 : shf_w[N-2:0];
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = BUSY;
          mcand_d  = {{(N-1){1'b0}}, i_multiplicand[N-2:0]};
          mplier_d = i_multiplier[N-2:0];
          sign_d   = i_multiplicand[N-1] ^ i_multiplier[N-1];
          acc_d    = '0;
          cnt_d    = CW'(N-1);
        end
      end
      BUSY: begin
        acc_d    = sum_w;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          dcnt_d    = 2'd0;
          ovf_d     = ovf_w;
          product_d = {sign_q & (|mag_w), mag_w};
        end
      end
      DONE: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == 2'd2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_product_out = product_q;
  assign o_overflow    = ovf_q;
  assign o_complete    = (state_q == DONE);
  assign o_busy        = (state_q != IDLE);

endmodule
